// File: rtl/dds_gen.sv
// dds_gen: direct digital synthesis waveform generator.
//
// A phase accumulator advances by a loadable tuning word on each enabled clock.
// The accumulator's top LUT_AW bits plus a phase offset form the phase. That phase
// selects one of four waveforms: sine from an internal table, square, triangle or
// sawtooth. The pipeline has three stages, with 2 clocks from an accumulator update
// to its sample.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         1 = accumulate, 0 = accumulator held at zero
//   load       strobe capturing fword / pword / wave_sel into shadow registers
//   fword      frequency tuning word (phase increment per clock)
//   pword      phase offset at LUT resolution
//   wave_sel   0 sine, 1 square, 2 triangle, 3 sawtooth
//   dout       unsigned offset-binary sample
//   dout_valid dout derives from an enabled accumulator cycle
//   phase_wrap pulse on the sample whose accumulator update overflowed
module dds_gen #(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned LUT_AW = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [ACC_W-1:0]  fword,
    input  logic [LUT_AW-1:0] pword,
    input  logic [1:0]        wave_sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              phase_wrap
);

    localparam int unsigned LutDepth = 1 << LUT_AW;
    localparam int unsigned FracBits = 28;
    localparam longint      PiFix    = 64'sd843314857; // round(pi * 2^28)

    // Elaboration-time sine entry in 2^-28 fixed point: fold into the first
    // quadrant, then a Taylor series to x^19 (error far below one output LSB).
    function automatic logic [DATA_W-1:0] sine_entry(input int k);
        longint depth, half_depth, quarter, kk, j, x, x2, term, sum, amp, mid, mag, res;
        logic   neg;
        depth      = longint'(LutDepth);
        half_depth = depth / 2;
        quarter    = depth / 4;
        kk         = longint'(k) % depth;
        neg        = (kk >= half_depth);
        if (neg) kk = kk - half_depth;
        j    = (kk > quarter) ? (half_depth - kk) : kk;
        x    = (PiFix * j) / (2 * quarter);
        x2   = (x * x) >>> FracBits;
        term = x;
        sum  = x;
        for (int n = 1; n <= 9; n++) begin
            term = -(((term * x2) >>> FracBits) / longint'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        amp = (longint'(1) << (DATA_W - 1)) - 1;
        mid = longint'(1) << (DATA_W - 1);
        mag = (amp * sum + (longint'(1) << (FracBits - 1))) >>> FracBits;
        res = neg ? (mid - mag) : (mid + mag);
        return res[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] sine_rom [LutDepth];

    for (genvar k = 0; k < LutDepth; k++) begin : g_rom
        assign sine_rom[k] = sine_entry(k);
    end

    // Shadow configuration and stage 0 (accumulator)
    logic [ACC_W-1:0]  fw_r;
    logic [LUT_AW-1:0] pw_r;
    logic [1:0]        ws_r;
    logic [ACC_W-1:0]  acc_q;
    logic              carry_q;
    logic              v0_q;
    logic [ACC_W:0]    acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, fw_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw_r    <= '0;
            pw_r    <= '0;
            ws_r    <= 2'd0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            v0_q    <= 1'b0;
        end else begin
            if (load) begin
                fw_r <= fword;
                pw_r <= pword;
                ws_r <= wave_sel;
            end
            // acc_sum reads the pre-load fw_r, so a new word applies one cycle later
            if (en) begin
                acc_q   <= acc_sum[ACC_W-1:0];
                carry_q <= acc_sum[ACC_W];
                v0_q    <= 1'b1;
            end else begin
                acc_q   <= '0;
                carry_q <= 1'b0;
                v0_q    <= 1'b0;
            end
        end
    end

    // Stage 1: phase with its waveform, valid and wrap tags
    logic [LUT_AW-1:0] phase_q;
    logic [1:0]        ws1_q;
    logic              wrap1_q;
    logic              v1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            ws1_q   <= 2'd0;
            wrap1_q <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            phase_q <= acc_q[ACC_W-1 -: LUT_AW] + pw_r;
            ws1_q   <= ws_r;
            wrap1_q <= carry_q;
            v1_q    <= v0_q;
        end
    end

    // Stage 2: waveform decode and output registers
    logic [LUT_AW-2:0] tri_t;
    logic [LUT_AW-1:0] tri_full;
    logic [DATA_W-1:0] wave_d;

    always_comb begin
        tri_t    = phase_q[LUT_AW-1] ? ~phase_q[LUT_AW-2:0] : phase_q[LUT_AW-2:0];
        tri_full = {tri_t, 1'b0};
        wave_d   = '0;
        unique case (ws1_q)
            2'd0: wave_d = sine_rom[phase_q];
            2'd1: wave_d = phase_q[LUT_AW-1] ? '0 : '1;
            2'd2: wave_d = tri_full[LUT_AW-1 -: DATA_W];
            2'd3: wave_d = phase_q[LUT_AW-1 -: DATA_W];
            default: wave_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            phase_wrap <= 1'b0;
        end else begin
            dout_valid <= v1_q;
            phase_wrap <= wrap1_q;
            // Hold the last valid sample once the pipeline drains
            if (v1_q) dout <= wave_d;
        end
    end

endmodule

// File: tb/tb_dds_gen.sv
// Self-checking directed bench for dds_gen at default parameters.
module tb_dds_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [23:0] fword;
    logic [7:0]  pword;
    logic [1:0]  wave_sel;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        phase_wrap;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dds_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .fword      (fword),
        .pword      (pword),
        .wave_sel   (wave_sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .phase_wrap (phase_wrap)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        fword = '0; pword = '0; wave_sel = 2'd0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    // Reset, load a configuration, enable; returns after the 2nd accumulate,
    // so the next tick produces the first valid sample.
    task automatic start_run(input logic [23:0] fw, input logic [7:0] pw, input logic [1:0] ws);
        do_reset;
        load = 1'b1; fword = fw; pword = pw; wave_sel = ws;
        tick;
        load = 1'b0;
        en = 1'b1;
        tick; tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; load = 1'b1; fword = 24'h123456; pword = 8'h40; wave_sel = 2'd1;
        tick; tick;
        n_checks++;
        if (dout !== 8'h00) begin
            n_errors++; $display("FAIL reset_dout: got %h want 00", dout);
        end
        n_checks++;
        if (dout_valid !== 1'b0 || phase_wrap !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags: got v=%b w=%b want 0 0", dout_valid, phase_wrap);
        end
        load = 1'b0; en = 1'b0;
        rst_n = 1'b1;
        tick; tick; tick;
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_errors++; $display("FAIL idle_valid: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_sine_sweep;
        int idx;
        logic [7:0] exp_d;
        logic chk;
        do_reset;
        load = 1'b1; fword = 24'h010000; pword = 8'h00; wave_sel = 2'd0;
        tick;
        load = 1'b0; en = 1'b1;
        tick;
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_errors++; $display("FAIL sine_lat1: got v=%b want 0", dout_valid);
        end
        tick;
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_errors++; $display("FAIL sine_lat2: got v=%b want 0", dout_valid);
        end
        for (int n = 0; n < 512; n++) begin
            tick;
            idx = (n + 1) % 256;
            n_checks++;
            if (dout_valid !== 1'b1 || phase_wrap !== (idx == 0)) begin
                n_errors++;
                $display("FAIL sine_flags idx %0d: got v=%b w=%b want 1 %b",
                         idx, dout_valid, phase_wrap, idx == 0);
            end
            chk = 1'b1;
            case (idx)
                0:   exp_d = 8'h80;
                1:   exp_d = 8'h83;
                2:   exp_d = 8'h86;
                3:   exp_d = 8'h89;
                32:  exp_d = 8'hDA;
                64:  exp_d = 8'hFF;
                65:  exp_d = 8'hFF;
                128: exp_d = 8'h80;
                160: exp_d = 8'h26;
                192: exp_d = 8'h01;
                default: begin exp_d = 8'h00; chk = 1'b0; end
            endcase
            if (chk) begin
                n_checks++;
                if (dout !== exp_d) begin
                    n_errors++; $display("FAIL sine_entry %0d: got %h want %h", idx, dout, exp_d);
                end
            end
        end
    endtask

    task automatic test_phase_offset;
        logic [7:0] exp_d;
        logic chk;
        start_run(24'h010000, 8'h40, 2'd0);
        for (int n = 0; n < 256; n++) begin
            tick;
            chk = 1'b1;
            case (n)
                0:   exp_d = 8'hFF; // entry 65
                63:  exp_d = 8'h80; // entry 128
                95:  exp_d = 8'h26; // entry 160
                127: exp_d = 8'h01; // entry 192
                255: exp_d = 8'hFF; // entry 64, wrap sample
                default: begin exp_d = 8'h00; chk = 1'b0; end
            endcase
            if (chk) begin
                n_checks++;
                if (dout !== exp_d) begin
                    n_errors++; $display("FAIL poff_sample %0d: got %h want %h", n, dout, exp_d);
                end
            end
            n_checks++;
            if (phase_wrap !== (n == 255)) begin
                n_errors++; $display("FAIL poff_wrap %0d: got %b want %b", n, phase_wrap, n == 255);
            end
        end
    endtask

    task automatic test_square;
        int p;
        logic [7:0] exp_d;
        logic [7:0] prev;
        prev = 8'h00;
        start_run(24'h010000, 8'h00, 2'd1);
        for (int n = 0; n < 300; n++) begin
            tick;
            p = (n + 1) % 256;
            exp_d = (p < 128) ? 8'hFF : 8'h00;
            n_checks++;
            if (dout !== exp_d || phase_wrap !== (p == 0)) begin
                n_errors++;
                $display("FAIL square p=%0d: got %h w=%b want %h w=%b",
                         p, dout, phase_wrap, exp_d, p == 0);
            end
            if (p == 0) begin
                n_checks++;
                if (prev !== 8'h00 || dout !== 8'hFF) begin
                    n_errors++; $display("FAIL square_edge: got %h->%h want 00->ff", prev, dout);
                end
            end
            prev = dout;
        end
    endtask

    task automatic test_sawtooth;
        // -1 per sample at LUT resolution
        start_run(24'hFF0000, 8'h00, 2'd3);
        for (int n = 0; n < 8; n++) begin
            tick;
            n_checks++;
            if (dout !== 8'(8'hFF - n) || phase_wrap !== (n != 0)) begin
                n_errors++;
                $display("FAIL saw_ff0000 %0d: got %h w=%b want %h w=%b",
                         n, dout, phase_wrap, 8'(8'hFF - n), n != 0);
            end
        end
        // -1 per clock in the LSB; the top byte stays 0xFF for a long time
        start_run(24'hFFFFFF, 8'h00, 2'd3);
        for (int n = 0; n < 6; n++) begin
            tick;
            n_checks++;
            if (dout !== 8'hFF || phase_wrap !== (n != 0)) begin
                n_errors++;
                $display("FAIL saw_ffffff %0d: got %h w=%b want ff w=%b",
                         n, dout, phase_wrap, n != 0);
            end
        end
    endtask

    task automatic test_triangle_desc;
        logic [7:0] exp_d [3] = '{8'hFA, 8'h08, 8'hF2};
        logic       exp_w [3] = '{1'b0, 1'b1, 1'b0};
        start_run(24'h820000, 8'h00, 2'd2);
        for (int n = 0; n < 3; n++) begin
            tick;
            n_checks++;
            if (dout !== exp_d[n] || phase_wrap !== exp_w[n]) begin
                n_errors++;
                $display("FAIL tri_desc %0d: got %h w=%b want %h w=%b",
                         n, dout, phase_wrap, exp_d[n], exp_w[n]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_d [9] = '{8'd4, 8'd6, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd12, 8'd12};
        logic       exp_v [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        start_run(24'h010000, 8'h00, 2'd2);
        tick;
        n_checks++;
        if (dout !== 8'd2 || dout_valid !== 1'b1) begin
            n_errors++; $display("FAIL tri_first: got %h v=%b want 02 v=1", dout, dout_valid);
        end
        // Reconfigure to sawtooth at double rate in a single strobe
        load = 1'b1; fword = 24'h020000; wave_sel = 2'd3;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) en = 1'b0;
            tick;
            load = 1'b0;
            n_checks++;
            if (dout !== exp_d[i] || dout_valid !== exp_v[i] || phase_wrap !== 1'b0) begin
                n_errors++;
                $display("FAIL switch_step %0d: got %h v=%b w=%b want %h v=%b w=0",
                         i, dout, dout_valid, phase_wrap, exp_d[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_zero_fword;
        start_run(24'h000000, 8'h40, 2'd0);
        for (int n = 0; n < 10; n++) begin
            tick;
            n_checks++;
            if (dout !== 8'hFF || dout_valid !== 1'b1 || phase_wrap !== 1'b0) begin
                n_errors++;
                $display("FAIL zero_fword %0d: got %h v=%b w=%b want ff v=1 w=0",
                         n, dout, dout_valid, phase_wrap);
            end
        end
    endtask

    task automatic test_mid_reset;
        start_run(24'h010000, 8'h00, 2'd0);
        for (int n = 0; n < 40; n++) tick;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (dout !== 8'h00 || dout_valid !== 1'b0 || phase_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got %h v=%b w=%b want 00 v=0 w=0",
                     dout, dout_valid, phase_wrap);
        end
        tick;
        rst_n = 1'b1;
        tick;
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_errors++; $display("FAIL post_reset_lat1: got v=%b want 0", dout_valid);
        end
        tick;
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_errors++; $display("FAIL post_reset_lat2: got v=%b want 0", dout_valid);
        end
        for (int n = 0; n < 5; n++) begin
            tick;
            n_checks++;
            if (dout !== 8'h80 || dout_valid !== 1'b1 || phase_wrap !== 1'b0) begin
                n_errors++;
                $display("FAIL post_reset %0d: got %h v=%b w=%b want 80 v=1 w=0",
                         n, dout, dout_valid, phase_wrap);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        fword = '0; pword = '0; wave_sel = 2'd0;
        test_reset;
        test_sine_sweep;
        test_phase_offset;
        test_square;
        test_sawtooth;
        test_triangle_desc;
        test_back_to_back;
        test_zero_fword;
        test_mid_reset;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
